// File: rtl/wb_load_store_unit.sv
// Wishbone pipelined initiator for RV32I loads/stores: one outstanding access,
// byte-lane steering, load extension, misalignment and timeout errors.
module wb_load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_err,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_addr,
    output logic [XLEN-1:0] o_wb_data,
    output logic [3:0]      o_wb_sel,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            we_q;
    logic            accept;
    logic            illegal;
    logic            timed_out;
    logic [3:0]      sel_d;
    logic [XLEN-1:0] wdat_d;
    logic [XLEN-1:0] load_data;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    assign o_req_ready  = (state == IDLE) && !i_reset;
    assign o_resp_valid = (state == RESP);
    assign accept       = i_req_valid && o_req_ready;
    // cnt holds the number of REQ/WAIT cycles already completed
    assign timed_out    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        illegal = 1'b0;
        case (i_req_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default: ;
        endcase
        if (i_req_we && i_req_funct3[2])
            illegal = 1'b1;
        if (i_req_funct3[1:0] == 2'b01 && i_req_addr[0])
            illegal = 1'b1;
        if (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00)
            illegal = 1'b1;

        case (i_req_funct3[1:0])
            2'b00: begin
                sel_d  = 4'b0001 << i_req_addr[1:0];
                wdat_d = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                sel_d  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                wdat_d = {2{i_req_wdata[15:0]}};
            end
            default: begin
                sel_d  = 4'b1111;
                wdat_d = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_b = i_wb_data[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
        case (f3_q[1:0])
            2'b00:   load_data = {{(XLEN-8){lane_b[7] & !f3_q[2]}}, lane_b};
            2'b01:   load_data = {{(XLEN-16){lane_h[15] & !f3_q[2]}}, lane_h};
            default: load_data = i_wb_data;
        endcase
        if (we_q)
            load_data = '0;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = illegal ? RESP : REQ;
            // timeout wins over a late stall release so the counter cannot run past its limit
            REQ: begin
                if (timed_out)        state_d = RESP;
                else if (!i_wb_stall) state_d = WAIT;
            end
            WAIT: if (i_wb_ack || timed_out) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            we_q         <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_wb_sel     <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q  <= i_req_funct3;
                        off_q <= i_req_addr[1:0];
                        we_q  <= i_req_we;
                        cnt   <= '0;
                        if (illegal) begin
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= '0;
                        end else begin
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= i_req_we;
                            o_wb_addr <= {i_req_addr[XLEN-1:2], 2'b00};
                            o_wb_sel  <= sel_d;
                            o_wb_data <= wdat_d;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (timed_out || !i_wb_stall)
                        o_wb_stb <= 1'b0;
                    if (timed_out) begin
                        o_resp_err   <= 1'b1;
                        o_resp_rdata <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (i_wb_ack) begin
                        o_resp_err   <= 1'b0;
                        o_resp_rdata <= load_data;
                    end else if (timed_out) begin
                        o_resp_err   <= 1'b1;
                        o_resp_rdata <= '0;
                    end
                end
                RESP: begin
                    o_resp_err   <= 1'b0;
                    o_resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_load_store_unit.md
# wb_load_store_unit

Wishbone pipelined bus initiator that carries the hart's RV32I loads and stores to the data-side responder (the block RAM). It accepts one request at a time from the execute stage, converts RISC-V width and sign encoding into byte lanes, drives stb/we/sel/addr/data while honouring stall, and waits for ack. It then returns the aligned, sign- or zero-extended load result, or an error on misalignment or timeout.

## Interface
- `XLEN`, 32, data and address width; only 32 is supported.
- `TIMEOUT`, 255, cycles without ack before the transaction is abandoned; must be ≥ 2.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  execute stage presents a request.
- `o_req_ready`  out  1  `state==IDLE && !i_reset`; a request is taken when valid and ready are both high.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RISC-V funct3. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- `i_req_addr`  in  XLEN  byte address.
- `i_req_wdata`  in  XLEN  store data, right-aligned.
- `o_resp_valid`  out  1  one-cycle completion pulse.
- `o_resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `o_resp_err`  out  1  qualifies `o_resp_valid`; indicates misaligned access, illegal funct3 or timeout.
- `o_wb_stb`, `o_wb_we`  out  1  Wishbone strobe and write enable.
- `o_wb_addr`  out  XLEN  `{addr[XLEN-1:2],2'b00}`.
- `o_wb_data`  out  XLEN  lane-replicated write data.
- `o_wb_sel`  out  4  byte-lane enables.
- `i_wb_data`  in  XLEN  read data; valid with ack.
- `i_wb_stall`, `i_wb_ack`  in  1  responder stall and acknowledge.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - On handshake, decode the request.
  - Illegal request → RESP with err=1. A request is illegal if it is:
    - funct3 ∈ {011,110,111};
    - a store with funct3[2]=1;
    - LH/LHU/SH with addr[0]=1;
    - LW/SW with addr[1:0]≠0.
  - Illegal requests produce no bus activity.
  - Legal request → REQ. All `o_wb_*` are registered on that edge; `o_wb_we` = `i_req_we`.
- **Lane rules**
  - Byte: sel = `4'b0001<<addr[1:0]`, data = `{4{wdata[7:0]}}`.
  - Half: sel = addr[1] ? `1100` : `0011`, data = `{2{wdata[15:0]}}`.
  - Word: sel = `1111`, data = wdata.
  - Loads use the same sel.
- **REQ**
  - stb is held, with all `o_wb_*` stable, until a cycle with `!i_wb_stall`.
  - On that edge, stb drops and the state goes to WAIT.
- **WAIT**
  - On `i_wb_ack`, latch the lane selected by addr[1:0] and funct3.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - → RESP with err=0.
- **RESP**
  - `o_resp_valid`=1 for exactly one cycle, then → IDLE.
- **Timeout**
  - A cycle counter clears on entering REQ and counts through REQ and WAIT.
  - When it reaches `TIMEOUT` without ack: drop stb, → RESP with err=1 and rdata=0.
- **Stray acks**
  - Ack while in REQ is a protocol violation and is ignored.
  - Ack in IDLE or RESP (for example, late after a timeout) is discarded.

## Timing
- All outputs are 0 during and after reset. The one exception is `o_req_ready`, which goes to 1 in the first cycle after reset deasserts.
- Reset asserted mid-transaction: stb drops asynchronously; the state returns to IDLE and no response is produced.
- **Best-case latency**
  - Handshake at edge 0.
  - stb high in cycle 1 with no stall.
  - Ack in cycle 2.
  - `o_resp_valid` in cycle 3.
  - `o_req_ready` back in cycle 4.
- Each stall cycle adds one cycle; each ack-wait cycle adds one cycle.
- Illegal request: `o_resp_valid` in the cycle after the handshake.
- There is no request pipelining: at most one outstanding transaction.
- `i_req_*` is sampled only on the handshake edge and may change afterwards.

## Test plan
- **SW** addr=0x10, wdata=0xDEADBEEF, no stall, ack next cycle → stb exactly one cycle, sel=1111, addr=0x10, we=1; resp_valid 3 cycles after handshake with err=0 and rdata=0.
- **LB** addr=0x13, bus word 0x80FF_1234 → sel=1000, rdata=0xFFFFFF80. Repeat as LBU → rdata=0x00000080. LHU addr=0x12 → sel=1100, rdata=0x000080FF.
- **SH with stall** addr=0x06, wdata=0x0000ABCD, stall high 3 cycles → stb high 4 cycles with stable sel=1100 and data=0xABCDABCD; exactly one transaction.
- **Misaligned LW** addr=0x02, and funct3=011 → no stb; resp_valid with err=1 on the next cycle.
- **Timeout** with `TIMEOUT`=8 and ack never asserted → resp err=1, rdata=0 at cycle 8 after stb. A late ack 2 cycles later is ignored, and the following LW completes normally.
- **Reset mid-WAIT** → stb=0, resp_valid=0, ready=1 after deassert; a subsequent store completes.
